// File: rtl/delay_arb_ctrl.sv
// Round-robin arbiter and sequencer sharing one done_count delay counter among NREQ requesters.
// Optional feature: define DELAY_ARB_ABORT_EN to abort a job when its requester drops req.
module delay_arb_ctrl #(
  parameter int N    = 8,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] len,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic              cnt_clr,
  output logic              cnt_ld,
  output logic              cnt_up,
  output logic [N-1:0]      cnt_D,
  input  logic              cnt_rco
);
  localparam int LW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

  state_t          state;
  logic [LW-1:0]   last, win, win_hi, win_any;
  logic            found_hi;
  logic [NREQ-1:0] win_oh;
  logic [N-1:0]    len_q, win_len;
  logic            abort;

  // Lowest requester above last wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    win_hi   = '0;
    win_any  = '0;
    found_hi = 1'b0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req[i]) begin
        win_any = LW'(i);
        if (LW'(i) > last) begin
          win_hi   = LW'(i);
          found_hi = 1'b1;
        end
      end
    end
    win     = found_hi ? win_hi : win_any;
    win_oh  = '0;
    win_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (LW'(i) == win) begin
        win_oh[i] = 1'b1;
        win_len   = len[i*N +: N];
      end
    end
  end

`ifdef DELAY_ARB_ABORT_EN
  assign abort = ((state == LOAD) || (state == COUNT)) && !(|(req & gnt));
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state <= IDLE;
      last  <= LW'(NREQ-1);
      gnt   <= '0;
      done  <= '0;
      len_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt   <= win_oh;
            last  <= win;
            len_q <= win_len;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            gnt   <= '0;
            state <= IDLE;
          end else begin
            state <= COUNT;
          end
        end
        COUNT: begin
          if (abort) begin
            gnt   <= '0;
            state <= IDLE;
          end else if (cnt_rco) begin
            done  <= gnt;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= '0;
          gnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Loading the complement makes the counter reach all ones after exactly len_q increments.
  assign cnt_D   = ~len_q;
  assign busy    = (state != IDLE);
  assign cnt_ld  = (state == LOAD);
  assign cnt_up  = (state == COUNT) && !cnt_rco;
  assign cnt_clr = !clr_n || abort;
endmodule
